// File: rtl/arp_pkg.sv
// Shared ARP opcode constants and the request FSM state encoding.
package arp_pkg;

    localparam logic ARP_OP_REQ   = 1'b1;
    localparam logic ARP_OP_REPLY = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        REQ_PEND,
        WAIT
    } req_state_t;

endpackage

// File: rtl/arp_down_cnt.sv
// Loadable down-counter that stops at zero; used for the reply timeout
// and for the cache-refresh interval.
module arp_down_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_reg;

    // Load has priority over counting; the count holds once it reaches zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - ONE;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/arp_tx_sched.sv
// ARP transmit scheduler: arbitrates replies and requests onto the transmit
// engine, retries requests on timeout and optionally refreshes the cache.
module arp_tx_sched
    import arp_pkg::*;
#(
    parameter int RETRY_CYCLES   = 125_000_000,
    parameter int MAX_RETRY      = 3,
    parameter int REFRESH_CYCLES = 0,
    parameter int CNT_W          = 32
) (
    input  logic clk,
    input  logic rstn,
    input  logic key,
    input  logic arp_rx_done,
    input  logic arp_rx_op,
    input  logic arp_tx_busy,
    output logic arp_tx_en,
    output logic arp_tx_op,
    output logic resolved,
    output logic fail
);

    localparam int               RW           = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0]    MAX_R        = RW'(MAX_RETRY);
    localparam bit               REFRESH_EN   = (REFRESH_CYCLES != 0);
    localparam logic [CNT_W-1:0] RETRY_LOAD   = CNT_W'(RETRY_CYCLES - 1);
    localparam logic [CNT_W-1:0] REFRESH_LOAD = CNT_W'(REFRESH_EN ? REFRESH_CYCLES - 1 : 0);

    req_state_t    state_reg, state_next;
    logic [RW-1:0] retry_cnt_reg, retry_cnt_next;
    logic          resolved_reg, resolved_next;
    logic          fail_reg, fail_next;
    logic          refresh_arm_reg, refresh_arm_next;
    logic          key_d_reg;
    logic          reply_pend_reg;
    logic          tx_en_reg;
    logic          tx_op_reg;

    logic key_edge, slot, issue_reply, issue_req;
    logic rx_req, rx_reply;
    logic timeout_load, timeout_zero;
    logic refresh_load, refresh_zero, refresh_fire;

    assign key_edge     = key & ~key_d_reg;
    assign rx_req       = arp_rx_done & (arp_rx_op == ARP_OP_REQ);
    assign rx_reply     = arp_rx_done & (arp_rx_op == ARP_OP_REPLY);
    // The engine raises busy up to one cycle after our pulse, so the cycle
    // right after a pulse is never a slot.
    assign slot         = ~arp_tx_busy & ~tx_en_reg;
    assign issue_reply  = slot & reply_pend_reg;
    assign issue_req    = slot & ~reply_pend_reg & (state_reg == REQ_PEND);
    assign refresh_fire = refresh_arm_reg & refresh_zero & (state_reg == IDLE);

    arp_down_cnt #(.CNT_W(CNT_W)) u_timeout_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     (timeout_load),
        .load_val (RETRY_LOAD),
        .en       (state_reg == WAIT),
        .zero     (timeout_zero)
    );

    arp_down_cnt #(.CNT_W(CNT_W)) u_refresh_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     (refresh_load),
        .load_val (REFRESH_LOAD),
        .en       ((state_reg == IDLE) & refresh_arm_reg),
        .zero     (refresh_zero)
    );

    // Request FSM state and status registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= IDLE;
            retry_cnt_reg   <= '0;
            resolved_reg    <= 1'b0;
            fail_reg        <= 1'b0;
            refresh_arm_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            retry_cnt_reg   <= retry_cnt_next;
            resolved_reg    <= resolved_next;
            fail_reg        <= fail_next;
            refresh_arm_reg <= refresh_arm_next;
        end
    end

    // Request FSM next state: trigger, issue, then wait for reply or timeout.
    always_comb begin
        state_next       = state_reg;
        retry_cnt_next   = retry_cnt_reg;
        resolved_next    = resolved_reg;
        fail_next        = 1'b0;
        refresh_arm_next = refresh_arm_reg;
        timeout_load     = 1'b0;
        refresh_load     = 1'b0;
        case (state_reg)
            IDLE: begin
                // A key edge also cancels any running refresh interval.
                if (key_edge || refresh_fire) begin
                    retry_cnt_next   = '0;
                    refresh_arm_next = 1'b0;
                    state_next       = REQ_PEND;
                end
            end
            REQ_PEND: begin
                if (issue_req) begin
                    timeout_load = 1'b1;
                    state_next   = WAIT;
                end
            end
            WAIT: begin
                // A reply coinciding with the timeout still counts as success.
                if (rx_reply) begin
                    resolved_next    = 1'b1;
                    refresh_load     = REFRESH_EN;
                    refresh_arm_next = REFRESH_EN;
                    state_next       = IDLE;
                end else if (timeout_zero) begin
                    if (retry_cnt_reg < MAX_R) begin
                        retry_cnt_next = retry_cnt_reg + RW'(1);
                        state_next     = REQ_PEND;
                    end else begin
                        fail_next     = 1'b1;
                        resolved_next = 1'b0;
                        state_next    = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Key edge history, pending reply flag and the transmit pulse/opcode.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_d_reg      <= 1'b0;
            reply_pend_reg <= 1'b0;
            tx_en_reg      <= 1'b0;
            tx_op_reg      <= 1'b0;
        end else begin
            key_d_reg <= key;
            tx_en_reg <= issue_reply | issue_req;
            // A request arriving in the issue cycle is merged into the reply being sent.
            if (issue_reply) begin
                reply_pend_reg <= 1'b0;
            end else if (rx_req) begin
                reply_pend_reg <= 1'b1;
            end
            if (issue_reply) begin
                tx_op_reg <= ARP_OP_REPLY;
            end else if (issue_req) begin
                tx_op_reg <= ARP_OP_REQ;
            end
        end
    end

    assign arp_tx_en = tx_en_reg;
    assign arp_tx_op = tx_op_reg;
    assign resolved  = resolved_reg;
    assign fail      = fail_reg;

endmodule
